// File: rtl/reuleaux_pkg.sv
// Shared types and constants for the Reuleaux-triangle sequencer.
// ARC_GATE_EN selects outline-only arc gating; undefined draws full circles.
package reuleaux_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        RUN,
        GAP,
        DONE
    } state_t;

    // sqrt(3)/6 and sqrt(3)/3 scaled by 2^9
    localparam int K_SQRT3_6 = 148;
    localparam int K_SQRT3_3 = 296;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

endpackage

// File: rtl/reuleaux_vertices.sv
// Registered vertex calculator: turns centre and width into the three
// triangle vertices, captured when load is high.
module reuleaux_vertices
    import reuleaux_pkg::*;
#(
    parameter int FRAC_BITS = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] cx,
    input  logic [7:0] cy,
    input  logic [7:0] d,
    output logic [7:0] v0_x,
    output logic [7:0] v0_y,
    output logic [7:0] v1_x,
    output logic [7:0] v1_y,
    output logic [7:0] v2_x,
    output logic [7:0] v2_y
);

    logic [16:0] prod_h1;
    logic [16:0] prod_h2;
    logic [9:0]  h1;
    logic [9:0]  h2;
    logic [9:0]  half_d;
    logic [9:0]  sum_v0_x;
    logic [9:0]  sum_v1_x;
    logic [9:0]  sum_v01_y;
    logic [9:0]  sum_v2_y;

    logic [7:0] v0_x_d, v0_y_d, v1_x_d, v1_y_d, v2_x_d, v2_y_d;
    logic [7:0] v0_x_q, v0_y_q, v1_x_q, v1_y_q, v2_x_q, v2_y_q;

    // Off-screen results simply wrap; the caller keeps the shape in range.
    always_comb begin
        prod_h1   = 17'(d) * 17'(K_SQRT3_6);
        prod_h2   = 17'(d) * 17'(K_SQRT3_3);
        h1        = 10'(prod_h1 >> FRAC_BITS);
        h2        = 10'(prod_h2 >> FRAC_BITS);
        half_d    = {3'b000, d[7:1]};
        sum_v0_x  = {2'b00, cx} + half_d;
        sum_v1_x  = {2'b00, cx} - half_d;
        sum_v01_y = {2'b00, cy} + h1;
        sum_v2_y  = {2'b00, cy} - h2;

        v0_x_d = v0_x_q;
        v0_y_d = v0_y_q;
        v1_x_d = v1_x_q;
        v1_y_d = v1_y_q;
        v2_x_d = v2_x_q;
        v2_y_d = v2_y_q;
        if (load) begin
            v0_x_d = 8'(sum_v0_x);
            v0_y_d = 8'(sum_v01_y);
            v1_x_d = 8'(sum_v1_x);
            v1_y_d = 8'(sum_v01_y);
            v2_x_d = cx;
            v2_y_d = 8'(sum_v2_y);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0_x_q <= '0;
            v0_y_q <= '0;
            v1_x_q <= '0;
            v1_y_q <= '0;
            v2_x_q <= '0;
            v2_y_q <= '0;
        end else begin
            v0_x_q <= v0_x_d;
            v0_y_q <= v0_y_d;
            v1_x_q <= v1_x_d;
            v1_y_q <= v1_y_d;
            v2_x_q <= v2_x_d;
            v2_y_q <= v2_y_d;
        end
    end

    assign v0_x = v0_x_q;
    assign v0_y = v0_y_q;
    assign v1_x = v1_x_q;
    assign v1_y = v1_y_q;
    assign v2_x = v2_x_q;
    assign v2_y = v2_y_q;

endmodule

// File: rtl/reuleaux_seq.sv
// Runs the circle engine once per triangle vertex and forwards only outline
// pixels. Define ARC_GATE_EN for outline gating; otherwise full circles pass.
module reuleaux_seq
    import reuleaux_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int FRAC_BITS  = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       finished,
    input  logic [2:0] colour,
    input  logic [7:0] centre_x,
    input  logic [7:0] centre_y,
    input  logic [7:0] diameter,
    output logic       circ_start,
    output logic [7:0] circ_centre_x,
    output logic [7:0] circ_centre_y,
    output logic [7:0] circ_radius,
    input  logic       circ_finished,
    input  logic [7:0] circ_x,
    input  logic [6:0] circ_y,
    input  logic       circ_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    state_t     state_q, state_d;
    logic [1:0] arc_q, arc_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic [7:0] cx_q, cx_d;
    logic [7:0] cy_q, cy_d;
    logic [7:0] d_q, d_d;
    logic [2:0] colour_q, colour_d;

    logic [7:0] v0_x, v0_y, v1_x, v1_y, v2_x, v2_y;
    logic       in_arc;

    reuleaux_vertices #(
        .FRAC_BITS(FRAC_BITS)
    ) u_vertices (
        .clk  (clk),
        .rst_n(rst_n),
        .load (state_q == CALC),
        .cx   (cx_q),
        .cy   (cy_q),
        .d    (d_q),
        .v0_x (v0_x),
        .v0_y (v0_y),
        .v1_x (v1_x),
        .v1_y (v1_y),
        .v2_x (v2_x),
        .v2_y (v2_y)
    );

    always_comb begin
        state_d   = state_q;
        arc_d     = arc_q;
        gap_cnt_d = gap_cnt_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        d_d       = d_q;
        colour_d  = colour_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cx_d     = centre_x;
                    cy_d     = centre_y;
                    d_d      = diameter;
                    colour_d = colour;
                    state_d  = CALC;
                end
            end
            CALC: begin
                arc_d   = 2'd0;
                state_d = RUN;
            end
            RUN: begin
                if (circ_finished) begin
                    gap_cnt_d = '0;
                    state_d   = (arc_q < 2'd2) ? GAP : DONE;
                end
            end
            // Engine must also drop its finished flag before the next run.
            GAP: begin
                if (gap_cnt_q < 8'(GAP_LAST)) begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
                if ((gap_cnt_q >= 8'(GAP_LAST)) && !circ_finished) begin
                    arc_d   = arc_q + 2'd1;
                    state_d = RUN;
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            arc_q     <= '0;
            gap_cnt_q <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            d_q       <= '0;
            colour_q  <= '0;
        end else begin
            state_q   <= state_d;
            arc_q     <= arc_d;
            gap_cnt_q <= gap_cnt_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            d_q       <= d_d;
            colour_q  <= colour_d;
        end
    end

    always_comb begin
        circ_centre_x = v1_x;
        circ_centre_y = v1_y;
        case (arc_q)
            2'd0: begin
                circ_centre_x = v2_x;
                circ_centre_y = v2_y;
            end
            2'd1: begin
                circ_centre_x = v0_x;
                circ_centre_y = v0_y;
            end
            default: ;
        endcase
    end

`ifdef ARC_GATE_EN
    // Boundary pixels belong to both neighbouring arcs; duplicates are fine.
    always_comb begin
        in_arc = 1'b0;
        case (arc_q)
            2'd0:    in_arc = ({1'b0, circ_y} >= v0_y);
            2'd1:    in_arc = (circ_x <= cx_q) && ({1'b0, circ_y} <= v0_y);
            default: in_arc = (circ_x >= cx_q) && ({1'b0, circ_y} <= v0_y);
        endcase
    end
`else
    assign in_arc = 1'b1;
`endif

    assign circ_start  = (state_q == RUN);
    assign finished    = (state_q == DONE);
    assign circ_radius = d_q;
    assign vga_x       = circ_x;
    assign vga_y       = circ_y;
    assign vga_colour  = colour_q;
    assign vga_plot    = circ_plot && (state_q == RUN) && in_arc;

endmodule

// File: doc/reuleaux_seq.md
Name: reuleaux_seq

Overview:
Sequencer that sits directly upstream of the circle engine and also filters its pixel stream. It converts a Reuleaux-triangle request (centre, diameter, colour) into three triangle vertices. It then runs the circle engine three times, one run per vertex, with radius = diameter. Only the arc segment that belongs to the Reuleaux outline is forwarded to the VGA plot port.

Parameters:
GAP_CYCLES, 2, minimum cycles circ_start is held low between engine runs
FRAC_BITS, 9, fractional bits of the sqrt(3) constants

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  request; held high until finished is seen
finished  out  1  all three arcs drawn; held until start low
colour  in  3  pixel colour
centre_x  in  8  triangle centre x
centre_y  in  8  triangle centre y
diameter  in  8  Reuleaux width, which is also the arc radius
circ_start  out  1  start to circle engine
circ_centre_x  out  8  current vertex x
circ_centre_y  out  8  current vertex y
circ_radius  out  8  equals latched diameter
circ_finished  in  1  circle engine done
circ_x  in  8  engine pixel x
circ_y  in  7  engine pixel y
circ_plot  in  1  engine plot strobe
vga_x  out  8  forwarded pixel x
vga_y  out  7  forwarded pixel y
vga_colour  out  3  latched colour
vga_plot  out  1  gated plot strobe

Behaviour:
- Clocking and reset: single clock clk; synchronous active-low reset rst_n.
- Reset values: state IDLE, finished=0, circ_start=0, vga_plot=0, arc index=0, latched regs=0.
- States: IDLE, CALC, RUN, GAP, DONE.
- IDLE: on start=1, latch centre_x, centre_y, diameter and colour, then go to CALC.
- CALC (1 cycle): register the three vertices, then go to RUN with arc index 0.
- Vertex arithmetic: 10-bit unsigned intermediates.
  - h1 = (d*148)>>9, h2 = (d*296)>>9, both truncated.
  - V0 = (cx+d/2, cy+h1); V1 = (cx-d/2, cy+h1); V2 = (cx, cy-h2).
  - d/2 = d>>1.
  - Results are truncated to 8 bits, so wrap-around is the caller's responsibility.
- RUN: circ_start=1, circ_centre is the vertex for the current arc index (0→V2, 1→V0, 2→V1).
  - On circ_finished=1: go to GAP if index<2, else go to DONE.
- GAP: circ_start=0. Stay at least GAP_CYCLES cycles and until circ_finished=0, then increment index and go to RUN.
- DONE: finished=1, circ_start=0. On start=0, go to IDLE with finished=0 on the next cycle.
- start dropping mid-run is ignored; the sequence always completes.
- vga_x=circ_x and vga_y=circ_y, combinational passthrough with 0-cycle latency.
- vga_colour = latched colour.
- vga_plot = circ_plot AND state==RUN AND in_arc. in_arc depends on the arc:
  - arc0: circ_y >= V0.y.
  - arc1: circ_x <= cx AND circ_y <= V0.y.
  - arc2: circ_x >= cx AND circ_y <= V0.y.
- Pixels on the boundary row/column are plotted by both adjacent arcs; duplicates are acceptable.
- Reset mid-run: next edge returns to IDLE with circ_start=0 and vga_plot=0.

Optional Feature:
ARC_GATE_EN
- Defined: in_arc gating as above.
- Undefined: in_arc is forced to 1, so three full circles are drawn (geometry debug).
- Handshake and timing are identical in both builds.

Decomposition:
- Package reuleaux_pkg holds:
  - state enum (IDLE, CALC, RUN, GAP, DONE)
  - K_SQRT3_6=148, K_SQRT3_3=296
  - SCREEN_W=160, SCREEN_H=120
- One sub-module, reuleaux_vertices: registered vertex calculator (inputs cx, cy, d, load; outputs V0..V2).

Test Plan:
- Vertex calc: cx=80, cy=60, d=80 → V0=(120,83), V1=(40,83), V2=(80,14); circ_radius=80.
- Three-run handshake with a behavioural engine asserting finished 20 cycles after start:
  - exactly three circ_start rising edges with centres V2, V0, V1;
  - ≥2 low cycles between runs;
  - finished rises after the third run.
- Gating: in arc1 (centre V0), engine pixel (100,50) → vga_plot=0; pixel (45,70) → vga_plot=1. In arc0, pixel (80,94) → vga_plot=1.
- Completion hold: keep start=1 after finished → finished stays 1 and no new circ_start; drop start → IDLE next cycle, finished=0.
- Reset mid-run: rst_n=0 during arc1 → next edge circ_start=0, vga_plot=0, finished=0. A fresh start then re-runs from arc0.
- ARC_GATE_EN undefined: all circ_plot pulses during RUN appear on vga_plot.
